opb_register_ppc2simulink_sync: RTL and testbench

//  - OPB slave software register, written by the PPC and driven into user (Simulink) fabric logic.
//  - Write direction of the software-register pair; the existing block covers user->PPC reads.
//  - Single clock domain: user logic runs on OPB_Clk.
//  - PPC writes land in a byte-maskable shadow register.
//  - The shadow is committed to user_data_out with a one-cycle user_data_valid strobe,

---
 rtl/opb_register_ppc2simulink_sync_pkg.sv | 26 ++
 rtl/opb_register_ppc2simulink_sync_if.sv | 29 ++
 rtl/opb_register_ppc2simulink_sync_opb_slave.sv | 69 ++++++
 rtl/opb_register_ppc2simulink_sync.sv | 92 +++++++++
 tb/tb_opb_register_ppc2simulink_sync.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/opb_register_ppc2simulink_sync_pkg.sv
// Shared definitions for the PPC-to-user software register.
// Provides the register word offsets, the slave FSM state type and a
// byte-lane merge helper for big-endian [0:31] OPB buses.
package opb_register_ppc2simulink_sync_pkg;

  localparam logic [31:0] OFFS_DATA   = 32'h0000_0000;
  localparam logic [31:0] OFFS_STATUS = 32'h0000_0004;

  typedef enum logic [0:0] {
    StIdle,
    StAck
  } state_e;

  // BE[i] selects byte lane bus[8*i +: 8]; lane 0 is the most significant byte.
  function automatic logic [0:31] be_merge(input logic [0:31] old_word,
                                           input logic [0:31] new_word,
                                           input logic [0:3]  be);
    logic [0:31] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/opb_register_ppc2simulink_sync_if.sv
// OPB slave-side bus bundle.
//   master modport: drives OPB_* request signals, receives Sl_* responses.
//   slave modport:  receives OPB_* request signals, drives Sl_* responses.
// Buses use OPB big-endian numbering: bit 0 is the MSB.
interface opb_register_ppc2simulink_sync_if;

  logic [0:31] OPB_ABus;
  logic [0:3]  OPB_BE;
  logic [0:31] OPB_DBus;
  logic        OPB_RNW;
  logic        OPB_select;
  logic        OPB_seqAddr;
  logic [0:31] Sl_DBus;
  logic        Sl_xferAck;
  logic        Sl_errAck;
  logic        Sl_retry;
  logic        Sl_toutSup;

  modport master (
    output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );

  modport slave (
    input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );

endinterface

// File: rtl/opb_register_ppc2simulink_sync_opb_slave.sv
// OPB slave front end: address decode, IDLE/ACK handshake FSM and read-data gating.
// Ports:
//   OPB_Clk, OPB_Rst   clock, async active-high reset
//   bus                OPB slave modport
//   rd_data            read data for the offset currently being acked
//   acc_valid          high during the ACK cycle of an accepted access
//   acc_offs           word offset of the accepted access (low 2 bits zero)
//   acc_rnw/be/data    captured direction, byte enables and write data
module opb_register_ppc2simulink_sync_opb_slave
  import opb_register_ppc2simulink_sync_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR = 32'h0100_0400,
  parameter logic [31:0] C_HIGHADDR = 32'h0100_04FF
) (
  input  logic                                  OPB_Clk,
  input  logic                                  OPB_Rst,
  opb_register_ppc2simulink_sync_if.slave       bus,
  input  logic [0:31]                           rd_data,
  output logic                                  acc_valid,
  output logic [31:0]                           acc_offs,
  output logic                                  acc_rnw,
  output logic [0:3]                            acc_be,
  output logic [0:31]                           acc_data
);

  state_e      state_q;
  logic [31:0] addr;
  logic [31:0] offs;
  logic        hit;
  logic [2:0]  unused_bits;

  assign addr = bus.OPB_ABus;
  assign offs = addr - C_BASEADDR;
  assign hit  = bus.OPB_select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
  assign unused_bits = {offs[1:0], bus.OPB_seqAddr};

  // New requests are only taken in StIdle, so a held select acks every other cycle.
  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      state_q  <= StIdle;
      acc_offs <= '0;
      acc_rnw  <= 1'b0;
      acc_be   <= '0;
      acc_data <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (hit) begin
            state_q  <= StAck;
            acc_offs <= {offs[31:2], 2'b00};
            acc_rnw  <= bus.OPB_RNW;
            acc_be   <= bus.OPB_BE;
            acc_data <= bus.OPB_DBus;
          end
        end
        StAck:   state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign acc_valid      = (state_q == StAck);
  assign bus.Sl_xferAck = acc_valid;
  assign bus.Sl_DBus    = acc_valid ? rd_data : '0;
  assign bus.Sl_errAck  = 1'b0;
  assign bus.Sl_retry   = 1'b0;
  assign bus.Sl_toutSup = 1'b0;

endmodule

// File: rtl/opb_register_ppc2simulink_sync.sv
// PPC-written software register driven into user fabric logic.
// PPC writes land in a byte-maskable shadow; the shadow is committed to
// user_data_out with a one-cycle user_data_valid strobe whenever user_hold is low.
// Ports:
//   OPB_Clk, OPB_Rst   clock, async active-high reset
//   bus                OPB slave modport (DATA at +0x0, STATUS at +0x4)
//   user_data_out      committed value, [31] = OPB bit 0
//   user_data_valid    one-cycle pulse per commit
//   user_hold          defers commit while high
module opb_register_ppc2simulink_sync
  import opb_register_ppc2simulink_sync_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR    = 32'h0100_0400,
  parameter logic [31:0] C_HIGHADDR    = 32'h0100_04FF,
  parameter int unsigned C_OPB_AWIDTH  = 32,
  parameter int unsigned C_OPB_DWIDTH  = 32,
  parameter              C_FAMILY      = "virtex6",
  parameter logic [31:0] C_RESET_VALUE = 32'h0000_0000
) (
  input  logic                            OPB_Clk,
  input  logic                            OPB_Rst,
  opb_register_ppc2simulink_sync_if.slave bus,
  output logic [31:0]                     user_data_out,
  output logic                            user_data_valid,
  input  logic                            user_hold
);

  localparam bit ParamsOk = (C_OPB_AWIDTH == 32) && (C_OPB_DWIDTH == 32) &&
                            ($bits(C_FAMILY) > 0);

  if (!ParamsOk) begin : g_param_check
    $error("only 32-bit OPB address and data widths are supported");
  end

  logic        acc_valid;
  logic [31:0] acc_offs;
  logic        acc_rnw;
  logic [0:3]  acc_be;
  logic [0:31] acc_data;
  logic [0:31] rd_data;
  logic [0:31] shadow_q;
  logic        pending_q;
  logic        data_wr;

  opb_register_ppc2simulink_sync_opb_slave #(
    .C_BASEADDR (C_BASEADDR),
    .C_HIGHADDR (C_HIGHADDR)
  ) u_opb_slave (
    .OPB_Clk   (OPB_Clk),
    .OPB_Rst   (OPB_Rst),
    .bus       (bus),
    .rd_data   (rd_data),
    .acc_valid (acc_valid),
    .acc_offs  (acc_offs),
    .acc_rnw   (acc_rnw),
    .acc_be    (acc_be),
    .acc_data  (acc_data)
  );

  assign data_wr = acc_valid && !acc_rnw && (acc_offs == OFFS_DATA);

  always_comb begin
    rd_data = '0;
    if (acc_offs == OFFS_DATA) begin
      rd_data = shadow_q;
    end else if (acc_offs == OFFS_STATUS) begin
      rd_data = {30'b0, user_hold, pending_q};
    end
  end

  // A DATA write in its ACK cycle takes priority; the commit retries next cycle
  // with the merged shadow, so only the latest value ever reaches user logic.
  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      shadow_q        <= C_RESET_VALUE;
      user_data_out   <= C_RESET_VALUE;
      user_data_valid <= 1'b0;
      pending_q       <= 1'b0;
    end else begin
      user_data_valid <= 1'b0;
      if (data_wr) begin
        shadow_q  <= be_merge(shadow_q, acc_data, acc_be);
        pending_q <= 1'b1;
      end else if (pending_q && !user_hold) begin
        user_data_out   <= shadow_q;
        user_data_valid <= 1'b1;
        pending_q       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_opb_register_ppc2simulink_sync.sv
module tb_opb_register_ppc2simulink_sync;

  localparam logic [31:0] BASE  = 32'h0100_0400;
  localparam logic [31:0] HIGH  = 32'h0100_04FF;
  localparam logic [31:0] RSTV  = 32'hDEAD_BEEF;

  typedef struct {
    bit          rd;
    logic [31:0] data;
  } ack_exp_t;

  logic        clk;
  logic        rst;
  logic [31:0] user_data_out;
  logic        user_data_valid;
  logic        user_hold;

  int total;
  int bad;

  ack_exp_t    ack_q[$];
  logic [31:0] commit_q[$];

  opb_register_ppc2simulink_sync_if bus ();

  opb_register_ppc2simulink_sync #(
    .C_BASEADDR    (BASE),
    .C_HIGHADDR    (HIGH),
    .C_OPB_AWIDTH  (32),
    .C_OPB_DWIDTH  (32),
    .C_FAMILY      ("virtex6"),
    .C_RESET_VALUE (RSTV)
  ) dut (
    .OPB_Clk         (clk),
    .OPB_Rst         (rst),
    .bus             (bus),
    .user_data_out   (user_data_out),
    .user_data_valid (user_data_valid),
    .user_hold       (user_hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT acks or commits.
  always @(negedge clk) begin
    if (bus.Sl_xferAck) begin
      if (ack_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ack: got ack=1 expected none at %0t", $time);
      end else begin
        ack_exp_t e;
        e = ack_q.pop_front();
        if (e.rd) check("read_data", bus.Sl_DBus, e.data);
      end
    end else begin
      check("dbus_zero_idle", bus.Sl_DBus, 32'h0);
    end
    if (user_data_valid) begin
      if (commit_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got valid with out=%08h expected none at %0t",
                 user_data_out, $time);
      end else begin
        check("commit_value", user_data_out, commit_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One access; returns on the ACK-cycle edge.
  task automatic bus_access(input logic [31:0] addr, input bit rnw, input logic [3:0] be,
                            input logic [31:0] data, input logic [31:0] exp_rd);
    @(posedge clk);
    #1;
    bus.OPB_ABus   = addr;
    bus.OPB_RNW    = rnw;
    bus.OPB_BE     = be;
    bus.OPB_DBus   = data;
    bus.OPB_select = 1'b1;
    ack_q.push_back('{rd: rnw, data: exp_rd});
    @(posedge clk);
    #1;
    bus.OPB_select = 1'b0;
    check("ack_latency", {31'b0, bus.Sl_xferAck}, 32'h1);
    @(posedge clk);
  endtask

  initial begin
    int acks;
    bit prev_ack;
    total = 0;
    bad = 0;
    rst = 1'b1;
    user_hold = 1'b0;
    bus.OPB_ABus = '0;
    bus.OPB_BE = '0;
    bus.OPB_DBus = '0;
    bus.OPB_RNW = 1'b0;
    bus.OPB_select = 1'b0;
    bus.OPB_seqAddr = 1'b0;

    // 1. Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_out", user_data_out, RSTV);
    check("reset_sl", {27'b0, bus.Sl_xferAck, bus.Sl_errAck, bus.Sl_retry, bus.Sl_toutSup,
                       user_data_valid}, 32'h0);
    rst = 1'b0;
    bus_access(BASE + 32'h4, 1'b1, 4'hF, 32'h0, 32'h0);

    // 2. Full write and latency
    commit_q.push_back(32'h1234_5678);
    bus_access(BASE, 1'b0, 4'hF, 32'h1234_5678, 32'h0);
    #1;
    check("no_early_valid", {31'b0, user_data_valid}, 32'h0);
    @(posedge clk);
    #1;
    check("valid_latency", {31'b0, user_data_valid}, 32'h1);
    check("out_after_write", user_data_out, 32'h1234_5678);
    bus_access(BASE, 1'b1, 4'hF, 32'h0, 32'h1234_5678);

    // 3. Byte-lane merge
    commit_q.push_back(32'h12BB_56DD);
    bus_access(BASE, 1'b0, 4'b0101, 32'hAABB_CCDD, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("out_after_be", user_data_out, 32'h12BB_56DD);
    bus_access(BASE, 1'b1, 4'hF, 32'h0, 32'h12BB_56DD);

    // 4. Hold defers and merges
    #1;
    user_hold = 1'b1;
    bus_access(BASE, 1'b0, 4'hF, 32'h1111_1111, 32'h0);
    bus_access(BASE, 1'b0, 4'hF, 32'h2222_2222, 32'h0);
    bus_access(BASE + 32'h4, 1'b1, 4'hF, 32'h0, 32'h3);
    repeat (3) @(posedge clk);
    #1;
    check("out_held", user_data_out, 32'h12BB_56DD);
    commit_q.push_back(32'h2222_2222);
    user_hold = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("out_released", user_data_out, 32'h2222_2222);
    bus_access(BASE + 32'h4, 1'b1, 4'hF, 32'h0, 32'h0);
    bus_access(BASE + 32'h8, 1'b0, 4'hF, 32'h9999_9999, 32'h0);
    bus_access(BASE + 32'h8, 1'b1, 4'hF, 32'h0, 32'h0);

    // 5a. Miss held for 10 cycles
    @(posedge clk);
    #1;
    bus.OPB_ABus = HIGH + 32'h4;
    bus.OPB_RNW = 1'b1;
    bus.OPB_select = 1'b1;
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (bus.Sl_xferAck) acks++;
      check("miss_dbus", bus.Sl_DBus, 32'h0);
    end
    check("miss_acks", acks, 0);

    // 5b. Held select on DATA read
    bus.OPB_ABus = BASE;
    for (int i = 0; i < 5; i++) ack_q.push_back('{rd: 1'b1, data: 32'h2222_2222});
    acks = 0;
    prev_ack = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (bus.Sl_xferAck) begin
        acks++;
        if (prev_ack) check("double_ack", 32'h1, 32'h0);
      end
      prev_ack = bus.Sl_xferAck;
    end
    bus.OPB_select = 1'b0;
    check("held_acks", acks, 5);

    // 6. Reset during a write ACK cycle
    @(posedge clk);
    #1;
    bus.OPB_ABus = BASE;
    bus.OPB_RNW = 1'b0;
    bus.OPB_BE = 4'hF;
    bus.OPB_DBus = 32'h5555_5555;
    bus.OPB_select = 1'b1;
    @(posedge clk);
    #1;
    bus.OPB_select = 1'b0;
    check("ack_before_rst", {31'b0, bus.Sl_xferAck}, 32'h1);
    rst = 1'b1;
    #1;
    check("ack_dropped", {31'b0, bus.Sl_xferAck}, 32'h0);
    check("out_reset", user_data_out, RSTV);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("out_after_rst", user_data_out, RSTV);
    bus_access(BASE, 1'b1, 4'hF, 32'h0, RSTV);
    bus_access(BASE + 32'h4, 1'b1, 4'hF, 32'h0, 32'h0);

    repeat (3) @(posedge clk);
    #1;
    check("ack_q_empty", ack_q.size(), 0);
    check("commit_q_empty", commit_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
